reset_sequencer: RTL
====================

// Module: reset_sequencer
// PURPOSE
// - Owns PLL-lock qualification and reset sequencing for the SoC, between the PLL and the icicle core.
// - Waits for a stable lock, then releases peripheral reset before core reset.
// - Re-asserts both resets on lock loss, a software reset request or watchdog expiry.
// - Records the cause of the last reset for software.
// PARAMETERS
// HOLD_CYCLES  16  cycles lock must stay high before periph_reset releases (>=1)
// STAGGER      4   cycles between periph_reset release and core_reset release (>=1)
// WDT_WIDTH    24  watchdog counter width; expiry when counter reaches all-ones
// PORTS
// clk               in   1  the single clock (PLL output clock domain)
// reset             in   1  power-on reset; asynchronous, active-low
// pll_locked_async  in   1  raw PLL lock; asynchronous to clk
// sw_reset_req      in   1  software reset request, one-cycle pulse from MMIO
// wdt_enable        in   1  watchdog enable, level
// wdt_kick          in   1  watchdog kick, one-cycle pulse
// periph_reset      out  1  active-high reset for peripherals (UART, flash, LEDs)
// core_reset        out  1  active-high reset for the icicle core
// ready             out  1  high only in RUN
// reset_cause       out  2  00 POR, 01 lock loss, 10 software, 11 watchdog
// BEHAVIOUR
// - One clock. Reset is asynchronous and active-low.
// - While reset=0 (async):
//   - state=WAIT_LOCK, counters=0, sync flops=0.
//   - periph_reset=1, core_reset=1, ready=0, reset_cause=00.
// - pll_locked_async passes through an internal 2-flop synchronizer; locked is valid 2 edges after the input rises.
// - All outputs are registered, with no combinational path from inputs.
// - WAIT_LOCK
//   - cnt=0, both resets high.
//   - locked=1 -> HOLD with cnt=0.
// - HOLD
//   - locked=0 -> WAIT_LOCK, cnt=0.
//   - cnt==HOLD_CYCLES-1 -> REL_PERIPH, periph_reset<=0, cnt=0.
//   - Otherwise cnt++.
// - REL_PERIPH
//   - locked=0 -> WAIT_LOCK, periph_reset<=1, cause<=01.
//   - cnt==STAGGER-1 -> RUN, core_reset<=0, ready<=1.
//   - Otherwise cnt++.
// - RUN, events checked in priority order:
//   - locked=0 -> WAIT_LOCK, cause<=01.
//   - Watchdog expiry -> HOLD, cause<=11.
//   - sw_reset_req=1 -> HOLD, cause<=10.
//   - In all three cases, on the same edge: both resets<=1, ready<=0, cnt=0.
// - Latency from the pll_locked_async rise (edge 0): periph_reset falls at edge 3+HOLD_CYCLES; core_reset falls at edge 3+HOLD_CYCLES+STAGGER.
// - Software reset latency: sw_reset_req sampled at edge N.
//   - Resets are high after edge N.
//   - periph_reset falls at edge N+HOLD_CYCLES.
//   - core_reset falls at edge N+HOLD_CYCLES+STAGGER.
// - sw_reset_req outside RUN is ignored (not queued).
// - reset_cause holds until the next reset event; only reset=0 returns it to 00.
// - Lock glitch during HOLD restarts qualification. Lock loss while reset is already asserted does not change cause.
// CONFIGURATION
// - Macro WATCHDOG_EN defined:
//   - WDT_WIDTH-bit counter runs only in RUN with wdt_enable=1; cleared otherwise, on wdt_kick, and on any RUN exit.
//   - Expiry occurs when the counter reaches all-ones.
//   - Kick on the expiry cycle wins: counter cleared, no reset.
// - Macro WATCHDOG_EN not defined:
//   - No watchdog counter.
//   - wdt_enable and wdt_kick are present but ignored.
//   - reset_cause never takes 11.
// TESTING (HOLD_CYCLES=16, STAGGER=4, WDT_WIDTH=8 for watchdog tests)
// 1. reset=0 then released; pll_locked_async rises at edge 0 -> periph_reset=0 at edge 19, core_reset=0 and ready=1 at edge 23, cause=00.
// 2. Lock drops for 1 cycle at edge 10 (during HOLD) -> no release before edge 19+restart; periph_reset falls exactly 16 edges after HOLD re-entry.
// 3. In RUN, pulse sw_reset_req at edge N -> both resets=1 at N; periph_reset=0 at N+16; core_reset=0 at N+20; cause=10.
// 4. In RUN, lock lost at edge M -> resets=1, ready=0, cause=01 after M+2 (sync delay); lock return replays test 1 timing with cause still 01.
// 5. WATCHDOG_EN, wdt_enable=1, no kicks -> reset after 255 RUN cycles, cause=11; kicking every 100 cycles -> no reset for 10000 cycles.
// 6. sw_reset_req and lock loss on the same edge in RUN -> cause=01, state WAIT_LOCK; assert reset=0 mid-HOLD -> all outputs at reset values immediately.

Source files
------------

// File: rtl/reset_sequencer.sv
// reset_sequencer: PLL-lock qualification, staged peripheral/core reset release and reset-cause capture.
// Define WATCHDOG_EN to build the RUN-state watchdog; without it wdt_enable/wdt_kick are ignored.
module reset_sequencer #(
    parameter int HOLD_CYCLES = 16,
    parameter int STAGGER     = 4,
    parameter int WDT_WIDTH   = 24
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pll_locked_async,
    input  logic       sw_reset_req,
    input  logic       wdt_enable,
    input  logic       wdt_kick,
    output logic       periph_reset,
    output logic       core_reset,
    output logic       ready,
    output logic [1:0] reset_cause
);
    // state         | meaning
    // ST_WAIT_LOCK  | both resets held, waiting for synchronized lock
    // ST_HOLD       | lock seen, counting HOLD_CYCLES of uninterrupted lock
    // ST_REL_PERIPH | peripheral reset released, counting STAGGER before core
    // ST_RUN        | both resets released, ready high
    typedef enum logic [1:0] {
        ST_WAIT_LOCK  = 2'd0,
        ST_HOLD       = 2'd1,
        ST_REL_PERIPH = 2'd2,
        ST_RUN        = 2'd3
    } state_t;

    localparam int MAX_CNT = (HOLD_CYCLES > STAGGER) ? HOLD_CYCLES : STAGGER;
    localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAG_LAST = CNT_W'(STAGGER - 1);

    localparam logic [1:0] CAUSE_POR  = 2'b00;
    localparam logic [1:0] CAUSE_LOCK = 2'b01;
    localparam logic [1:0] CAUSE_SW   = 2'b10;
    localparam logic [1:0] CAUSE_WDT  = 2'b11;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sync1_q, locked_q;
    logic             periph_q, periph_d;
    logic             core_q, core_d;
    logic             ready_q, ready_d;
    logic [1:0]       cause_q, cause_d;
    logic             wdt_expire;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q  <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            sync1_q  <= pll_locked_async;
            locked_q <= sync1_q;
        end
    end

`ifdef WATCHDOG_EN
    logic [WDT_WIDTH-1:0] wdt_q, wdt_d;

    // A kick on the all-ones cycle suppresses the expiry and clears the count.
    assign wdt_expire = (state_q == ST_RUN) && wdt_enable && !wdt_kick && (wdt_q == '1);

    always_comb begin
        wdt_d = '0;
        if ((state_q == ST_RUN) && (state_d == ST_RUN) && wdt_enable && !wdt_kick) begin
            wdt_d = wdt_q + WDT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wdt_q <= '0;
        end else begin
            wdt_q <= wdt_d;
        end
    end
`else
    logic unused_wdt;

    assign wdt_expire = 1'b0;
    assign unused_wdt = wdt_enable ^ wdt_kick ^ (WDT_WIDTH == 0);
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        periph_d = periph_q;
        core_d   = core_q;
        ready_d  = ready_q;
        cause_d  = cause_q;

        case (state_q)
            ST_WAIT_LOCK: begin
                cnt_d    = '0;
                periph_d = 1'b1;
                core_d   = 1'b1;
                ready_d  = 1'b0;
                if (locked_q) begin
                    state_d = ST_HOLD;
                end
            end

            ST_HOLD: begin
                periph_d = 1'b1;
                core_d   = 1'b1;
                ready_d  = 1'b0;
                if (!locked_q) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d  = ST_REL_PERIPH;
                    periph_d = 1'b0;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_REL_PERIPH: begin
                if (!locked_q) begin
                    state_d  = ST_WAIT_LOCK;
                    periph_d = 1'b1;
                    cause_d  = CAUSE_LOCK;
                    cnt_d    = '0;
                end else if (cnt_q == STAG_LAST) begin
                    state_d = ST_RUN;
                    core_d  = 1'b0;
                    ready_d = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_RUN: begin
                cnt_d = '0;
                // Lock loss outranks watchdog, which outranks a software request.
                if (!locked_q) begin
                    state_d = ST_WAIT_LOCK;
                    cause_d = CAUSE_LOCK;
                end else if (wdt_expire) begin
                    state_d = ST_HOLD;
                    cause_d = CAUSE_WDT;
                end else if (sw_reset_req) begin
                    state_d = ST_HOLD;
                    cause_d = CAUSE_SW;
                end
                if (state_d != ST_RUN) begin
                    periph_d = 1'b1;
                    core_d   = 1'b1;
                    ready_d  = 1'b0;
                end
            end

            default: begin
                state_d  = ST_WAIT_LOCK;
                cnt_d    = '0;
                periph_d = 1'b1;
                core_d   = 1'b1;
                ready_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_WAIT_LOCK;
            cnt_q    <= '0;
            periph_q <= 1'b1;
            core_q   <= 1'b1;
            ready_q  <= 1'b0;
            cause_q  <= CAUSE_POR;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            periph_q <= periph_d;
            core_q   <= core_d;
            ready_q  <= ready_d;
            cause_q  <= cause_d;
        end
    end

    assign periph_reset = periph_q;
    assign core_reset   = core_q;
    assign ready        = ready_q;
    assign reset_cause  = cause_q;

endmodule
